// File: rtl/state_fork.sv
// state_fork: duplicates one valid/ready state stream onto two branches
// (State0 = forward input, State1 = training input). A beat retires once
// every branch enabled by its latched mode has handshaked. BURST="yes"
// adds a one-entry skid so upstream ready is a pure register output and
// the fork sustains one beat per cycle.
module state_fork #(
    parameter int unsigned NP    = 8,
    parameter int unsigned WF    = 5,
    parameter string       BURST = "yes"
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iMode,
    input  logic               iValid_AM_State,
    output logic               oReady_AM_State,
    input  logic [NP*WF-1:0]   iData_AM_State,
    output logic               oValid_BM_State0,
    input  logic               iReady_BM_State0,
    output logic [NP*WF-1:0]   oData_BM_State0,
    output logic               oValid_BM_State1,
    input  logic               iReady_BM_State1,
    output logic [NP*WF-1:0]   oData_BM_State1
);

    localparam bit BURST_EN = (BURST == "yes");

    // main stage
    logic [NP*WF-1:0] data_reg, data_next;
    logic             pend0, pend0_next;
    logic             pend1, pend1_next;

    // skid stage (held at reset values when BURST_EN is 0)
    logic [NP*WF-1:0] skid_data, skid_data_next;
    logic             skid_mode, skid_mode_next;
    logic             skid_v, skid_v_next;

    logic c0, c1, free, acc, ready;

    assign c0    = pend0 & iReady_BM_State0;
    assign c1    = pend1 & iReady_BM_State1;
    assign free  = (~pend0 | c0) & (~pend1 | c1);
    assign ready = BURST_EN ? ~skid_v : (~pend0 & ~pend1);
    assign acc   = iValid_AM_State & ready;

    assign oReady_AM_State  = ready;
    assign oValid_BM_State0 = pend0;
    assign oValid_BM_State1 = pend1;
    assign oData_BM_State0  = data_reg;
    assign oData_BM_State1  = data_reg;

    // Next-state: pending bits drop on their own handshake; a reload sets
    // both afresh (pend1 from the beat's latched mode). The skid entry is
    // drained into the main stage before any direct load, keeping FIFO order.
    always_comb begin
        data_next      = data_reg;
        pend0_next     = pend0 & ~c0;
        pend1_next     = pend1 & ~c1;
        skid_data_next = skid_data;
        skid_mode_next = skid_mode;
        skid_v_next    = skid_v;
        if (BURST_EN) begin
            if (free && skid_v) begin
                data_next  = skid_data;
                pend0_next = 1'b1;
                pend1_next = skid_mode;
                if (acc) begin
                    skid_data_next = iData_AM_State;
                    skid_mode_next = iMode;
                end else begin
                    skid_v_next = 1'b0;
                end
            end else if (free && acc) begin
                data_next  = iData_AM_State;
                pend0_next = 1'b1;
                pend1_next = iMode;
            end else if (acc) begin
                skid_data_next = iData_AM_State;
                skid_mode_next = iMode;
                skid_v_next    = 1'b1;
            end
        end else if (acc) begin
            data_next  = iData_AM_State;
            pend0_next = 1'b1;
            pend1_next = iMode;
        end
    end

    // State registers with synchronous reset; reset discards all held beats.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            data_reg  <= '0;
            pend0     <= 1'b0;
            pend1     <= 1'b0;
            skid_data <= '0;
            skid_mode <= 1'b0;
            skid_v    <= 1'b0;
        end else begin
            data_reg  <= data_next;
            pend0     <= pend0_next;
            pend1     <= pend1_next;
            skid_data <= skid_data_next;
            skid_mode <= skid_mode_next;
            skid_v    <= skid_v_next;
        end
    end

endmodule

// File: tb/tb_state_fork.sv
// tb_state_fork: directed checks of state_fork in BURST="yes" (dut) and
// BURST="no" (dut_nb) configurations with hand-computed expectations.
module tb_state_fork;

    localparam int unsigned NP = 8;
    localparam int unsigned WF = 5;
    localparam int unsigned W  = NP * WF;

    logic clk = 1'b0;
    logic rst;

    // BURST="yes" instance signals
    logic         mode, valid, ready, v0, r0, v1, r1;
    logic [W-1:0] din, d0, d1;

    // BURST="no" instance signals
    logic         n_mode, n_valid, n_ready, n_v0, n_r0, n_v1, n_r1;
    logic [W-1:0] n_din, n_d0, n_d1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    state_fork #(.NP(NP), .WF(WF), .BURST("yes")) dut (
        .iCLK             (clk),
        .iRST             (rst),
        .iMode            (mode),
        .iValid_AM_State  (valid),
        .oReady_AM_State  (ready),
        .iData_AM_State   (din),
        .oValid_BM_State0 (v0),
        .iReady_BM_State0 (r0),
        .oData_BM_State0  (d0),
        .oValid_BM_State1 (v1),
        .iReady_BM_State1 (r1),
        .oData_BM_State1  (d1)
    );

    state_fork #(.NP(NP), .WF(WF), .BURST("no")) dut_nb (
        .iCLK             (clk),
        .iRST             (rst),
        .iMode            (n_mode),
        .iValid_AM_State  (n_valid),
        .oReady_AM_State  (n_ready),
        .iData_AM_State   (n_din),
        .oValid_BM_State0 (n_v0),
        .iReady_BM_State0 (n_r0),
        .oData_BM_State0  (n_d0),
        .oValid_BM_State1 (n_v1),
        .iReady_BM_State1 (n_r1),
        .oData_BM_State1  (n_d1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_cnt;
        logic [7:0] beat_mode;

        rst = 1'b1; mode = 1'b1; valid = 1'b1; din = W'(8'h15); r0 = 1'b1; r1 = 1'b1;
        n_mode = 1'b1; n_valid = 1'b0; n_din = '0; n_r0 = 1'b1; n_r1 = 1'b1;

        // 1: reset with valid held high
        tick();
        tick();
        rst = 1'b0;
        check("rst_v0", 64'(v0), 64'd0);
        check("rst_v1", 64'(v1), 64'd0);
        check("rst_rdy", 64'(ready), 64'd1);
        check("rst_nb_rdy", 64'(n_ready), 64'd1);
        tick();
        check("rst1_v0", 64'(v0), 64'd1);
        check("rst1_v1", 64'(v1), 64'd1);
        check("rst1_d0", 64'(d0), 64'h15);
        valid = 1'b0;
        tick();
        check("rst1_done_v0", 64'(v0), 64'd0);
        check("rst1_done_v1", 64'(v1), 64'd0);

        // 2: back-to-back 1..8, both branches ready, training mode
        valid = 1'b1; din = W'(1);
        check("b2b_pre_v0", 64'(v0), 64'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("b2b_v0", 64'(v0), 64'd1);
            check("b2b_v1", 64'(v1), 64'd1);
            check("b2b_d0", 64'(d0), 64'(k));
            check("b2b_d1", 64'(d1), 64'(k));
            check("b2b_rdy", 64'(ready), 64'd1);
            if (k == 8) valid = 1'b0;
            else din = W'(k + 1);
        end
        tick();
        check("b2b_end_v0", 64'(v0), 64'd0);
        check("b2b_end_v1", 64'(v1), 64'd0);

        // 3: branch 1 stalled for 5 cycles
        valid = 1'b1; din = W'(8'h2A); r1 = 1'b0;
        tick();
        check("stall_e1_v0", 64'(v0), 64'd1);
        check("stall_e1_d0", 64'(d0), 64'h2A);
        check("stall_e1_rdy", 64'(ready), 64'd1);
        din = W'(8'h2B);
        tick();
        check("stall_e2_v0", 64'(v0), 64'd0);
        check("stall_e2_v1", 64'(v1), 64'd1);
        check("stall_e2_d1", 64'(d1), 64'h2A);
        check("stall_e2_rdy", 64'(ready), 64'd0);
        din = W'(8'h2C);
        for (int k = 3; k <= 5; k++) begin
            tick();
            check("stall_hold_v0", 64'(v0), 64'd0);
            check("stall_hold_v1", 64'(v1), 64'd1);
            check("stall_hold_d1", 64'(d1), 64'h2A);
            check("stall_hold_rdy", 64'(ready), 64'd0);
        end
        r1 = 1'b1;
        tick();
        check("stall_e6_v0", 64'(v0), 64'd1);
        check("stall_e6_v1", 64'(v1), 64'd1);
        check("stall_e6_d0", 64'(d0), 64'h2B);
        check("stall_e6_rdy", 64'(ready), 64'd1);
        tick();
        check("stall_e7_d0", 64'(d0), 64'h2C);
        check("stall_e7_v1", 64'(v1), 64'd1);
        valid = 1'b0;
        tick();
        check("stall_end_v0", 64'(v0), 64'd0);
        check("stall_end_v1", 64'(v1), 64'd0);

        // 4: alternating mode 0,1,0,1
        beat_mode = 8'b0000_1010;
        valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din = W'(8'h11 + k);
            mode = beat_mode[k];
            tick();
            check("mode_v0", 64'(v0), 64'd1);
            check("mode_d0", 64'(d0), 64'(8'h11 + k));
            check("mode_v1", 64'(v1), 64'(beat_mode[k]));
        end
        valid = 1'b0; mode = 1'b1;
        tick();
        check("mode_end_v0", 64'(v0), 64'd0);
        check("mode_end_v1", 64'(v1), 64'd0);

        // 5: BURST="no", continuous input, 1 beat per 2 cycles
        acc_cnt = 0;
        n_valid = 1'b1; n_din = W'(8'h31);
        for (int e = 1; e <= 8; e++) begin
            if (n_valid && n_ready) acc_cnt++;
            tick();
            if (e % 2 == 1) begin
                check("nb_v0", 64'(n_v0), 64'd1);
                check("nb_v1", 64'(n_v1), 64'd1);
                check("nb_d0", 64'(n_d0), 64'(8'h31 + (e - 1) / 2));
                check("nb_d1", 64'(n_d1), 64'(8'h31 + (e - 1) / 2));
                check("nb_rdy_busy", 64'(n_ready), 64'd0);
                n_din = W'(8'h31 + (e + 1) / 2);
            end else begin
                check("nb_v0_idle", 64'(n_v0), 64'd0);
                check("nb_rdy_free", 64'(n_ready), 64'd1);
            end
        end
        check("nb_accepts", 64'(acc_cnt), 64'd4);
        n_valid = 1'b0;

        // 6: reset with main stage and skid both full
        r0 = 1'b0; r1 = 1'b0; mode = 1'b1;
        valid = 1'b1; din = W'(8'h41);
        tick();
        din = W'(8'h42);
        tick();
        check("full_rdy", 64'(ready), 64'd0);
        check("full_d0", 64'(d0), 64'h41);
        rst = 1'b1;
        tick();
        check("midrst_v0", 64'(v0), 64'd0);
        check("midrst_v1", 64'(v1), 64'd0);
        check("midrst_rdy", 64'(ready), 64'd1);
        check("midrst_d0", 64'(d0), 64'd0);
        rst = 1'b0; r0 = 1'b1; r1 = 1'b1; din = W'(8'h44);
        tick();
        check("post_rst_v0", 64'(v0), 64'd1);
        check("post_rst_d0", 64'(d0), 64'h44);
        valid = 1'b0;
        tick();
        check("post_rst_idle_v0", 64'(v0), 64'd0);
        tick();
        check("no_replay_v0", 64'(v0), 64'd0);
        check("no_replay_v1", 64'(v1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
